// File: rtl/serializador_der_izq.sv
// Purpose: serialises two WIDTH-bit operands LSB first for the right-to-left
// magnitude comparator chain, tracks the running "A>B so far" state and
// reports the final active-low result with a one-cycle done pulse.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   start, a_in, b_in      load request (sampled in IDLE) and operands
//   busy                   operation in progress (SHIFT or DONE)
//   a_bit, b_bit           current bit pair (LSB of the shift registers)
//   bit_valid              bit pair is meaningful (SHIFT)
//   first_bit, last_bit    framing flags for bit 0 and bit WIDTH-1
//   x_state                running comparator state, registered
//   z_n                    result, 0 => A>B, 1 => A<=B
//   done                   one-cycle pulse, z_n valid on this cycle
module serializador_der_izq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             a_bit,
    output logic             b_bit,
    output logic             bit_valid,
    output logic             first_bit,
    output logic             last_bit,
    output logic             x_state,
    output logic             z_n,
    output logic             done
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [CNT_W-1:0] cnt;
    logic             x_next_c;

    // The bit lines are the LSBs of the shift registers; they drain to zero
    // on the final shift, so they read 0 outside SHIFT.
    assign a_bit = a_sh[0];
    assign b_bit = b_sh[0];

    // Comparator cell: the initial cell ignores the incoming state.
    always_comb begin
        x_next_c = 1'b0;
        if (cnt == '0) begin
            x_next_c = a_sh[0] & ~b_sh[0];
        end else begin
            x_next_c = (a_sh[0] & ~b_sh[0]) | (x_state & ~b_sh[0]) | (x_state & a_sh[0]);
        end
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            bit_valid <= 1'b0;
            first_bit <= 1'b0;
            last_bit  <= 1'b0;
            x_state   <= 1'b0;
            z_n       <= 1'b1;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state     <= SHIFT;
                        a_sh      <= a_in;
                        b_sh      <= b_in;
                        cnt       <= '0;
                        busy      <= 1'b1;
                        bit_valid <= 1'b1;
                        first_bit <= 1'b1;
                        last_bit  <= 1'b0;
                        // Fresh operation: x restarts so stale state is not shown on bit 0.
                        x_state   <= 1'b0;
                    end
                end
                SHIFT: begin
                    x_state <= x_next_c;
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state     <= DONE;
                        cnt       <= '0;
                        bit_valid <= 1'b0;
                        first_bit <= 1'b0;
                        last_bit  <= 1'b0;
                        z_n       <= ~x_next_c;
                        done      <= 1'b1;
                    end else begin
                        cnt       <= cnt + CNT_W'(1);
                        first_bit <= 1'b0;
                        last_bit  <= (cnt == CNT_W'(WIDTH - 2));
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
